rni_rbeat_ctl: RTL and testbench

Read-data beat sequencer for the RN-I AXI slave read return path. It takes one read descriptor at a time: start chunk, chunks required, and beats per chunk. It walks the 16-byte chunks of the cache line in wrap order and issues AXI R beats as each chunk's data becomes available in the read data buffer. It drives buffer-select, beat-index and `r_last`, and pulses chunk-done and request-done. It is the transmit-side counterpart of the write-data beat counter.

---
 rtl/rni_rbeat_ctl_pkg.sv | 25 ++
 rtl/rni_rot_pri_sel.sv | 33 +++
 rtl/rni_rbeat_ctl.sv | 133 +++++++++++++
 tb/tb_rni_rbeat_ctl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rni_rbeat_ctl_pkg.sv
// Shared types and sizing for the RN-I read-data beat sequencer and its helpers.
package rni_rbeat_ctl_pkg;

  localparam int unsigned NCHUNK = 4;
  localparam int unsigned BCW    = 4;
  localparam int unsigned IW     = $clog2(NCHUNK);

  typedef enum logic {
    RNI_RB_IDLE = 1'b0,
    RNI_RB_BUSY = 1'b1
  } rb_state_e;

  typedef struct packed {
    logic [NCHUNK-1:0]     ctmask;
    logic [NCHUNK-1:0]     pdmask;
    logic [NCHUNK*BCW-1:0] bcount_vec;
    logic                  last;
  } rb_desc_t;

  // Isolates the lowest set bit; tolerates a malformed multi-hot start mask.
  function automatic logic [NCHUNK-1:0] lowest_set(input logic [NCHUNK-1:0] m);
    return m & (~m + NCHUNK'(1));
  endfunction

endpackage

// File: rtl/rni_rot_pri_sel.sv
// Rotating priority select: first set bit of mask strictly after the one-hot base,
// wrapping around so the base itself is considered last.
module rni_rot_pri_sel
  import rni_rbeat_ctl_pkg::*;
(
  input  logic [NCHUNK-1:0] mask,
  input  logic [NCHUNK-1:0] base,
  output logic [NCHUNK-1:0] sel_c
);

  logic [IW-1:0] base_idx;
  logic [IW-1:0] pos;
  logic          found;

  // NCHUNK is a power of two, so index arithmetic wraps naturally.
  always_comb begin
    base_idx = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (base[i]) base_idx = IW'(i);
    end
    sel_c = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NCHUNK; k++) begin
      pos = base_idx + IW'(k);
      if (!found && mask[pos]) begin
        sel_c[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rni_rbeat_ctl.sv
// RN-I read-return beat sequencer: walks the requested chunks of a line in wrap
// order and issues one AXI R beat per cycle as buffered chunk data becomes valid.
module rni_rbeat_ctl
  import rni_rbeat_ctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NCHUNK-1:0]     req_ctmask,
  input  logic [NCHUNK-1:0]     req_pdmask,
  input  logic [NCHUNK*BCW-1:0] req_bcount_vec,
  input  logic                  req_last,
  input  logic [NCHUNK-1:0]     chunk_vld,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [NCHUNK-1:0]     r_chunk,
  output logic [BCW-1:0]        r_beat,
  output logic                  r_last,
  output logic                  bk_done,
  output logic                  rq_done
);

  rb_state_e             state_q, state_d;
  logic [NCHUNK-1:0]     rem_q, rem_d;
  logic [NCHUNK-1:0]     cur_q, cur_d;
  logic [BCW-1:0]        beat_q, beat_d;
  logic [NCHUNK*BCW-1:0] bcount_vec_q, bcount_vec_d;
  logic                  last_q, last_d;

  rb_desc_t              req_desc;
  logic [BCW-1:0]        cur_bc;
  logic [NCHUNK-1:0]     rem_left;
  logic [NCHUNK-1:0]     nxt_cur;
  logic                  beat_end;
  logic                  fire;

  assign req_desc = '{ctmask:     req_ctmask,
                      pdmask:     req_pdmask,
                      bcount_vec: req_bcount_vec,
                      last:       req_last};

  // One-hot AND-OR mux of the current chunk's beat-count field.
  always_comb begin
    cur_bc = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      cur_bc = cur_bc | (bcount_vec_q[i*BCW +: BCW] & {BCW{cur_q[i]}});
    end
  end

  assign rem_left = rem_q & ~cur_q;
  assign beat_end = (beat_q == cur_bc);

  rni_rot_pri_sel u_rot_pri_sel (
    .mask  (rem_left),
    .base  (cur_q),
    .sel_c (nxt_cur)
  );

  assign req_ready = (state_q == RNI_RB_IDLE);
  assign r_valid   = (state_q == RNI_RB_BUSY) && |(chunk_vld & cur_q);
  assign fire      = r_valid && r_ready;
  assign r_chunk   = cur_q;
  assign r_beat    = beat_q;
  assign r_last    = r_valid && last_q && beat_end && !(|rem_left);
  assign bk_done   = fire && beat_end;
  assign rq_done   = bk_done && !(|rem_left);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RNI_RB_IDLE;
      rem_q        <= '0;
      cur_q        <= '0;
      beat_q       <= '0;
      bcount_vec_q <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cur_q        <= cur_d;
      beat_q       <= beat_d;
      bcount_vec_q <= bcount_vec_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cur_d        = cur_q;
    beat_d       = beat_q;
    bcount_vec_d = bcount_vec_q;
    last_d       = last_q;
    case (state_q)
      RNI_RB_IDLE: begin
        if (req_valid) begin
          rem_d        = req_desc.pdmask | req_desc.ctmask;
          cur_d        = lowest_set(req_desc.ctmask);
          beat_d       = '0;
          bcount_vec_d = req_desc.bcount_vec;
          last_d       = req_desc.last;
          state_d      = RNI_RB_BUSY;
        end
      end
      RNI_RB_BUSY: begin
        if (fire) begin
          if (!beat_end) begin
            beat_d = beat_q + BCW'(1);
          end else begin
            beat_d = '0;
            rem_d  = rem_left;
            cur_d  = nxt_cur;
            if (!(|rem_left)) begin
              cur_d   = '0;
              state_d = RNI_RB_IDLE;
            end
          end
        end
      end
      default: state_d = RNI_RB_IDLE;
    endcase
  end

  // The buffer never withdraws a chunk while its beat is waiting on r_ready.
  a_vld_hold: assert property (@(posedge clk) disable iff (!rst)
    (r_valid && !r_ready) |=> r_valid);

`ifdef ASSERT_CHECKER_ON
  a_ct_onehot: assert property (@(posedge clk) disable iff (!rst)
    (req_valid && req_ready) |-> $onehot(req_ctmask));
`endif

endmodule

// File: tb/tb_rni_rbeat_ctl.sv
// Scoreboard bench for rni_rbeat_ctl: a driver pushes the expected beat list of each
// descriptor, a negedge monitor pops and compares whenever a beat is handshaken.
module tb_rni_rbeat_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctmask;
  logic [3:0]  req_pdmask;
  logic [15:0] req_bcount_vec;
  logic        req_last;
  logic [3:0]  chunk_vld;
  logic        r_valid;
  logic        r_ready;
  logic [3:0]  r_chunk;
  logic [3:0]  r_beat;
  logic        r_last;
  logic        bk_done;
  logic        rq_done;

  typedef struct {
    logic [3:0] chunk;
    logic [3:0] beat;
    logic       last;
    logic       bk;
    logic       rq;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  rni_rbeat_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ctmask     (req_ctmask),
    .req_pdmask     (req_pdmask),
    .req_bcount_vec (req_bcount_vec),
    .req_last       (req_last),
    .chunk_vld      (chunk_vld),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .r_chunk        (r_chunk),
    .r_beat         (r_beat),
    .r_last         (r_last),
    .bk_done        (bk_done),
    .rq_done        (rq_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: visit chunks in wrap order from the start chunk, emitting field+1 beats each.
  task automatic build(input logic [3:0] ct, input logic [3:0] pd,
                       input logic [15:0] bc, input logic last);
    int         s;
    logic [3:0] all;
    beat_t      tmp[$];
    beat_t      e;
    s = 0;
    for (int i = 3; i >= 0; i--) if (ct[i]) s = i;
    all = pd | ct;
    for (int k = 0; k < 4; k++) begin
      int i;
      int n;
      i = (s + k) % 4;
      if (all[i]) begin
        n = int'(bc[i*4 +: 4]) + 1;
        for (int b = 0; b < n; b++) begin
          e.chunk = 4'(1 << i);
          e.beat  = 4'(b);
          e.last  = 1'b0;
          e.bk    = (b == n - 1);
          e.rq    = 1'b0;
          tmp.push_back(e);
        end
      end
    end
    e      = tmp.pop_back();
    e.rq   = 1'b1;
    e.last = last;
    tmp.push_back(e);
    foreach (tmp[j]) exp_q.push_back(tmp[j]);
  endtask

  // Monitor: compares presented outputs against the head of the expected queue.
  always @(negedge clk) begin : mon
    beat_t e;
    logic  ev;
    logic  ef;
    if (rst) begin
      if (exp_q.size() == 0) begin
        check("idle_r_valid", r_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("idle_r_last", r_last, 0);
        check("idle_bk_done", bk_done, 0);
        check("idle_rq_done", rq_done, 0);
        check("idle_r_chunk", r_chunk, 0);
        check("idle_r_beat", r_beat, 0);
      end else begin
        e  = exp_q[0];
        ev = |(chunk_vld & e.chunk);
        ef = ev && r_ready;
        check("r_valid", r_valid, ev);
        check("busy_req_ready", req_ready, 0);
        check("r_chunk", r_chunk, e.chunk);
        check("r_beat", r_beat, e.beat);
        check("r_last", r_last, ev && e.last);
        check("bk_done", bk_done, ef && e.bk);
        check("rq_done", rq_done, ef && e.rq);
        if (ef) void'(exp_q.pop_front());
      end
    end
  end

  // rdy_mode: 0 always ready, 1 toggling, 2 random. grow: random chunk arrival,
  // otherwise a missing head chunk appears after 5 stalled cycles.
  task automatic run_desc(input logic [3:0] ct, input logic [3:0] pd, input logic [15:0] bc,
                          input logic last, input logic [3:0] vld_init, input bit grow,
                          input int rdy_mode, input int stop_left);
    int cyc;
    int stall;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) check("req_ready_timeout", 0, 1);
    chunk_vld      = vld_init;
    r_ready        = 1'b1;
    req_ctmask     = ct;
    req_pdmask     = pd;
    req_bcount_vec = bc;
    req_last       = last;
    req_valid      = 1'b1;
    @(posedge clk);
    build(ct, pd, bc, last);
    #1 req_valid = 1'b0;
    cyc   = 0;
    stall = 0;
    while (exp_q.size() > stop_left && cyc < 600) begin
      case (rdy_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = ~r_ready;
        default: r_ready = ($urandom % 4) != 0;
      endcase
      if (grow) begin
        chunk_vld = chunk_vld | (4'($urandom) & 4'($urandom));
      end else if (exp_q.size() > 0 && !(|(chunk_vld & exp_q[0].chunk))) begin
        stall++;
        if (stall >= 5) chunk_vld = 4'hF;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 600) begin
      check("desc_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_ctmask     = '0;
    req_pdmask     = '0;
    req_bcount_vec = '0;
    req_last       = 1'b0;
    chunk_vld      = '0;
    r_ready        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last", r_last, 0);
    check("rst_bk_done", bk_done, 0);
    check("rst_rq_done", rq_done, 0);
    check("rst_r_chunk", r_chunk, 0);
    check("rst_r_beat", r_beat, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_desc(4'b0001, 4'b0001, 16'h0000, 1'b1, 4'hF, 1'b0, 0, 0);
    run_desc(4'b0100, 4'b1111, 16'h1111, 1'b1, 4'hF, 1'b0, 0, 0);
    run_desc(4'b0010, 4'b1010, 16'h0020, 1'b1, 4'hF, 1'b0, 0, 0);
    run_desc(4'b0010, 4'b1010, 16'h0020, 1'b1, 4'b0010, 1'b0, 1, 0);
    run_desc(4'b0001, 4'b1111, 16'h3210, 1'b0, 4'h0, 1'b1, 2, 0);
    run_desc(4'b1000, 4'b1111, 16'hFFFF, 1'b1, 4'hF, 1'b0, 2, 0);

    // Reset while the third of eight beats is presented.
    run_desc(4'b0001, 4'b1111, 16'h1111, 1'b1, 4'hF, 1'b0, 0, 6);
    check("pre_rst_r_valid", r_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_r_valid", r_valid, 0);
    check("mid_rst_rq_done", rq_done, 0);
    check("mid_rst_req_ready", req_ready, 1);
    exp_q.delete();
    chunk_vld = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_req_ready", req_ready, 1);
    run_desc(4'b0100, 4'b0011, 16'h0102, 1'b1, 4'hF, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] bc;
      bc = 16'($urandom);
      if (($urandom % 2) == 0) bc = bc & 16'h3333;
      run_desc(4'(1 << ($urandom % 4)), 4'($urandom), bc, 1'($urandom),
               4'($urandom), 1'b1, 2, 0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
